// File: rtl/voice_scheduler_if.sv
// Event handshake from the note source and slot strobe bus to the NCO datapath.
// The slave modport is the scheduler side; the master modport is the producer/consumer side.
interface voice_scheduler_if #(
  parameter int unsigned IdxW = 2
);
  logic            ev_valid;
  logic            ev_ready;
  logic            ev_on;
  logic [6:0]      ev_note;
  logic            slot_valid;
  logic [IdxW-1:0] slot_idx;
  logic [6:0]      slot_note;
  logic            slot_active;
  logic            frame_done;

  modport master (
    output ev_valid, ev_on, ev_note,
    input  ev_ready, slot_valid, slot_idx, slot_note, slot_active, frame_done
  );

  modport slave (
    input  ev_valid, ev_on, ev_note,
    output ev_ready, slot_valid, slot_idx, slot_note, slot_active, frame_done
  );
endinterface

// File: rtl/voice_scheduler.sv
// Polyphony controller: allocates/frees voice slots from note events and, on each sample
// tick, walks the shared phase datapath through every slot followed by a frame-done pulse.
module voice_scheduler #(
  parameter int unsigned Voices = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trig_i,
  voice_scheduler_if.slave    vs_io,
  output logic [Voices-1:0]   active_mask_o,
  output logic                steal_o,
  output logic                trig_lost_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(Voices - 1);

  logic [1:0]        state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic [Voices-1:0] act_q, act_d;
  logic [6:0]        note_q [Voices];
  logic [6:0]        note_d [Voices];
  logic [IdxW-1:0]   steal_ptr_q, steal_ptr_d;

  logic              slot_valid_q, slot_valid_d;
  logic [IdxW-1:0]   slot_idx_q, slot_idx_d;
  logic [6:0]        slot_note_q, slot_note_d;
  logic              slot_active_q, slot_active_d;
  logic              frame_done_q, frame_done_d;
  logic              steal_q, steal_d;
  logic              trig_lost_q, trig_lost_d;
  logic [Voices-1:0] mask_q;

  logic              accept;
  logic              hit;
  logic              free_found;
  logic [IdxW-1:0]   free_idx;

  // TRIG wins over a same-cycle event, so ready drops combinationally with it.
  assign vs_io.ev_ready = (state_q == StIdle) && !trig_i && !rst_i;
  assign accept         = vs_io.ev_valid && vs_io.ev_ready;

  // Frame sequencer and registered slot strobe.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    slot_valid_d  = 1'b0;
    slot_idx_d    = slot_idx_q;
    slot_note_d   = slot_note_q;
    slot_active_d = slot_active_q;
    frame_done_d  = 1'b0;
    trig_lost_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (trig_i) begin
          state_d = StScan;
          cnt_d   = '0;
        end
      end
      StScan: begin
        slot_valid_d  = 1'b1;
        slot_idx_d    = cnt_q;
        slot_note_d   = note_q[cnt_q];
        slot_active_d = act_q[cnt_q];
        trig_lost_d   = trig_i;
        if (cnt_q == LastIdx) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end
      StDone: begin
        frame_done_d = 1'b1;
        trig_lost_d  = trig_i;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Voice table update for an accepted event.
  always_comb begin
    act_d       = act_q;
    note_d      = note_q;
    steal_ptr_d = steal_ptr_q;
    steal_d     = 1'b0;
    hit         = 1'b0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = 0; i < int'(Voices); i++) begin
      if (act_q[i] && (note_q[i] == vs_io.ev_note)) begin
        hit = 1'b1;
      end
      if (!act_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
    if (accept) begin
      if (vs_io.ev_on) begin
        if (!hit) begin
          if (free_found) begin
            act_d[free_idx]  = 1'b1;
            note_d[free_idx] = vs_io.ev_note;
          end else begin
            note_d[steal_ptr_q] = vs_io.ev_note;
            steal_ptr_d = (steal_ptr_q == LastIdx) ? '0 : steal_ptr_q + IdxW'(1);
            steal_d     = 1'b1;
          end
        end
      end else begin
        // Note fields are kept on release; only the active bit drops.
        for (int i = 0; i < int'(Voices); i++) begin
          if (act_q[i] && (note_q[i] == vs_io.ev_note)) begin
            act_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      act_q         <= '0;
      steal_ptr_q   <= '0;
      slot_valid_q  <= 1'b0;
      slot_idx_q    <= '0;
      slot_note_q   <= '0;
      slot_active_q <= 1'b0;
      frame_done_q  <= 1'b0;
      steal_q       <= 1'b0;
      trig_lost_q   <= 1'b0;
      mask_q        <= '0;
      for (int i = 0; i < int'(Voices); i++) begin
        note_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      act_q         <= act_d;
      note_q        <= note_d;
      steal_ptr_q   <= steal_ptr_d;
      slot_valid_q  <= slot_valid_d;
      slot_idx_q    <= slot_idx_d;
      slot_note_q   <= slot_note_d;
      slot_active_q <= slot_active_d;
      frame_done_q  <= frame_done_d;
      steal_q       <= steal_d;
      trig_lost_q   <= trig_lost_d;
      mask_q        <= act_d;
    end
  end

  assign vs_io.slot_valid  = slot_valid_q;
  assign vs_io.slot_idx    = slot_idx_q;
  assign vs_io.slot_note   = slot_note_q;
  assign vs_io.slot_active = slot_active_q;
  assign vs_io.frame_done  = frame_done_q;
  assign active_mask_o     = mask_q;
  assign steal_o           = steal_q;
  assign trig_lost_o       = trig_lost_q;

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Polyphony controller for the NCO datapath. Owns a table of VOICES note slots, allocates and frees them from note-on/note-off events via a valid/ready handshake.
- On every sample tick it sequences the shared phase-accumulator/step-ROM path through each voice slot, one slot per clock. The path is given one (index, note, active) triple per cycle, followed by a frame-done pulse that the mixer uses.

Parameters:
- VOICES, 4, number of voice slots (2..16).
- IDX_W, 2, width of the voice index; must satisfy 2^IDX_W >= VOICES.

Ports:
- CLK  in  1  system clock (100 MHz).
- RST  in  1  asynchronous, active-high reset.
- TRIG  in  1  sample-rate tick from the prescaler, one-cycle pulse.
- EV_VALID  in  1  note event valid.
- EV_READY  out  1  event accepted when EV_VALID && EV_READY at a rising CLK edge.
- EV_ON  in  1  1 = note-on, 0 = note-off.
- EV_NOTE  in  7  MIDI note number.
- SLOT_VALID  out  1  slot strobe to the phase datapath.
- SLOT_IDX  out  IDX_W  voice index being served.
- SLOT_NOTE  out  7  note of that voice; drives the step ROM address.
- SLOT_ACTIVE  out  1  voice is sounding; if 0 the datapath holds phase and outputs silence.
- FRAME_DONE  out  1  one-cycle pulse after the last slot of a frame.
- ACTIVE_MASK  out  VOICES  bit i = voice i active.
- STEAL  out  1  one-cycle pulse when a note-on evicted a voice.
- TRIG_LOST  out  1  one-cycle pulse when TRIG arrived outside IDLE.

Behaviour:
- Reset (async, RST=1):
  - state = IDLE.
  - All voice entries are inactive, with note 0.
  - Steal pointer = 0.
  - All registered outputs = 0: SLOT_VALID, SLOT_IDX, SLOT_NOTE, SLOT_ACTIVE, FRAME_DONE, STEAL, TRIG_LOST, ACTIVE_MASK.
  - EV_READY = 0 while RST is high.
  - RST asserted mid-frame aborts the frame; no FRAME_DONE is issued.
- States:
  - IDLE: EV_READY = !TRIG (combinational). TRIG=1 sets slot counter to 0 and moves to SCAN. TRIG has priority over events in the same cycle; the event is not consumed.
  - SCAN: for each counter value k = 0..VOICES-1, register SLOT_VALID=1, SLOT_IDX=k, SLOT_NOTE=note[k], SLOT_ACTIVE=active[k]. After k = VOICES-1, move to DONE. EV_READY = 0.
  - DONE: one cycle with FRAME_DONE=1 and SLOT_VALID=0, then return to IDLE. EV_READY = 0.
- Latency:
  - TRIG sampled at edge t gives the first slot strobe visible after edge t+1.
  - Slots are visible after edges t+1..t+VOICES; FRAME_DONE is visible after edge t+VOICES+1.
  - The next event can be accepted at edge t+VOICES+2. A frame takes VOICES+2 cycles, far below the 3125-cycle tick period.
- TRIG in SCAN or DONE is ignored, raises a TRIG_LOST pulse, and the frame in progress is unaffected.
- Note-on, evaluated in priority order:
  - (a) If any active voice already holds EV_NOTE, no table change (retrigger). The lowest matching index wins.
  - (b) Otherwise the lowest-index inactive voice gets note = EV_NOTE and active = 1.
  - (c) If all voices are active, the voice at the steal pointer is overwritten with EV_NOTE. The steal pointer then increments modulo VOICES (wraps VOICES-1 to 0), and STEAL pulses.
- Note-off:
  - Every active voice whose note equals EV_NOTE becomes inactive; its note field is retained.
  - No match: ignored, no pulse.
- Table updates take effect at the acceptance edge. ACTIVE_MASK is registered and reflects the table the cycle after the edge.
- A frame snapshots nothing: events cannot be accepted during SCAN/DONE, so the table is stable for the whole frame.

Test Plan:
- Reset then idle: RST pulse mid-SCAN → all outputs 0 immediately (asynchronous), state IDLE, EV_READY=1 after release, no FRAME_DONE.
- Allocation: note-on 60, 64, 67 in IDLE → ACTIVE_MASK=4'b0111. On TRIG, slots show (0,60,1), (1,64,1), (2,67,1), (3,0,0) on 4 consecutive cycles, then FRAME_DONE exactly 1 cycle later.
- Retrigger and off: note-on 60 again → mask unchanged 4'b0111. Note-off 64 → mask 4'b0101. Note-on 72 → fills voice 1, mask 4'b0111. Note-off 99 → no change.
- Steal and wrap: fill 4 voices (60, 62, 64, 65), then note-on 70, 71, 72, 73, 74 → voices 0, 1, 2, 3, 0 are overwritten in that order, one STEAL pulse each, steal pointer wraps to 1.
- Collision: TRIG and EV_VALID (note-on 50) in the same IDLE cycle → EV_READY=0, frame starts, and the event is accepted at the first IDLE cycle after FRAME_DONE. A TRIG during SCAN gives a TRIG_LOST pulse and exactly one FRAME_DONE.
